// File: rtl/div_pkg.sv
// Shared types and op encodings for the iterative divider.
package div_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIXUP,
        S_DONE
    } div_state_e;

    localparam int OP_WORD   = 2;
    localparam int OP_SIGNED = 1;
    localparam int OP_REM    = 0;

    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b000;
    localparam logic [2:0] REM   = 3'b011;
    localparam logic [2:0] REMU  = 3'b001;
    localparam logic [2:0] DIVW  = 3'b110;
    localparam logic [2:0] DIVUW = 3'b100;
    localparam logic [2:0] REMW  = 3'b111;
    localparam logic [2:0] REMUW = 3'b101;

endpackage

// File: rtl/div_step.sv
// One restoring division step on unsigned operands.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // Extra top bit: the shifted remainder can exceed XLEN bits when divisor > 2^(XLEN-1).
    logic [XLEN:0] shifted;
    logic          ge;

    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        ge       = (shifted >= {1'b0, divisor});
        quo_next = {quo[XLEN-2:0], ge};
        rem_next = ge ? (shifted[XLEN-1:0] - divisor) : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/div_iter_unit.sv
// Radix-2 iterative divider for RISC-V M divide/remainder ops, with early-out
// for divide-by-zero and signed overflow.
//   state  | meaning
//   IDLE   | waiting for a request, in_ready high
//   PREP   | operand extension, abs values, special-case detection
//   CALC   | one restoring step per cycle
//   FIXUP  | sign correction and quotient/remainder select
//   DONE   | result presented until out_ready
module div_iter_unit
    import div_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        return sgn ? XLEN'($signed(v)) : XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] v, input logic w);
        return w ? ext32(v[31:0], 1'b1) : v;
    endfunction

    div_state_e      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
    logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0] step_rem, step_quo;
    logic            is_word, is_signed, is_rem;
    logic [XLEN-1:0] dvd_eff, dvs_eff, dvd_abs, dvs_abs, min_neg;
    logic [XLEN-1:0] spec_sel, q_fix, r_fix, fix_sel;
    logic            dvd_neg, dvs_neg, div_zero, ovf;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // During PREP, quo_q/dvs_q still hold the raw operands latched at accept.
    always_comb begin
        is_word   = (XLEN == 64) && op_q[OP_WORD];
        is_signed = op_q[OP_SIGNED];
        is_rem    = op_q[OP_REM];
        dvd_eff   = is_word ? ext32(quo_q[31:0], is_signed) : quo_q;
        dvs_eff   = is_word ? ext32(dvs_q[31:0], is_signed) : dvs_q;
        dvd_neg   = is_signed && dvd_eff[XLEN-1];
        dvs_neg   = is_signed && dvs_eff[XLEN-1];
        dvd_abs   = dvd_neg ? -dvd_eff : dvd_eff;
        dvs_abs   = dvs_neg ? -dvs_eff : dvs_eff;
        min_neg   = is_word ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero  = (dvs_eff == '0);
        ovf       = is_signed && (dvd_eff == min_neg) && (dvs_eff == '1);
        spec_sel  = div_zero ? (is_rem ? dvd_eff : '1) : (is_rem ? '0 : dvd_eff);
        q_fix     = q_neg_q ? -quo_q : quo_q;
        r_fix     = r_neg_q ? -rem_q : rem_q;
        fix_sel   = is_rem ? r_fix : q_fix;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        result_d    = result_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (flush) begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_d    = S_PREP;
                        in_ready_d = 1'b0;
                        op_d       = op;
                        quo_d      = dividend;
                        dvs_d      = divisor;
                    end
                end
                S_PREP: begin
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    if (div_zero || ovf) begin
                        result_d    = fmt(spec_sel, is_word);
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        rem_d   = '0;
                        // W ops run 32 steps, so the dividend must start at the top of quo.
                        quo_d   = is_word ? (dvd_abs << 32) : dvd_abs;
                        dvs_d   = dvs_abs;
                        cnt_d   = is_word ? CNT_W'(32) : CNT_W'(XLEN);
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
                end
                S_FIXUP: begin
                    result_d    = fmt(fix_sel, is_word);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            result_q    <= result_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed ops, latency, backpressure, flush, reset.
module tb_div_iter_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;

    div_iter_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: latency on first out_valid, result on handshake.
    initial begin
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                pv = 1'b0;
            end else begin
                if (out_valid && !pv && sb.size() > 0)
                    check({sb[0].name, " latency"}, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                if (out_valid && out_ready && !flush) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected output: got %h want none", result);
                    end else begin
                        e = sb.pop_front();
                        check(e.name, result, e.res);
                    end
                end
                pv = out_valid;
            end
        end
    end

    task automatic start(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("in_ready wait");
        op       = o;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        acc      = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        op       = ~o;
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat);
        exp_t e;
        int   acc;
        start(o, a, b, acc);
        e.res  = exp;
        e.lat  = lat;
        e.acc  = acc;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            fail_now({"drain ", sb[0].name});
            sb.delete();
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!out_valid) fail_now(name);
    endtask

    initial begin
        int acc;
        repeat (3) @(negedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", result, 64'd0);
        rst = 1'b1;

        issue("DIVU 100/7", DIVU, 64'd100, 64'd7, 64'd14, 67);               drain();
        issue("REMU 100/7", REMU, 64'd100, 64'd7, 64'd2, 67);                drain();
        issue("DIV -7/2", DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67); drain();
        issue("REM -7/2", REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67); drain();
        issue("REM 7/-2", REM, 64'd7, -64'sd2, 64'd1, 67);                   drain();
        issue("DIV 100/-7", DIV, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 67); drain();
        issue("REM 100/-7", REM, 64'd100, -64'sd7, 64'd2, 67);               drain();
        issue("DIVU big", DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 67); drain();
        issue("REMU big", REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
              64'h7FFF_FFFF_FFFF_FFFE, 67);                                   drain();
        issue("DIVU 5/0", DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);   drain();
        issue("REM x/0", REM, 64'h8000_0000_0000_0005, 64'd0, 64'h8000_0000_0000_0005, 2); drain();
        issue("DIV ovf", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 2);                                    drain();
        issue("REM ovf", REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2); drain();
        issue("DIVW ovf", DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 2);                                    drain();
        issue("DIVUW", DIVUW, 64'h1_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 35); drain();
        issue("REMW", REMW, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 35); drain();

        // Backpressure: result held while out_ready is low.
        out_ready = 1'b0;
        issue("bp DIVU 5/0", DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        wait_valid("bp valid wait");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp result", result, 64'hFFFF_FFFF_FFFF_FFFF);
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        drain();

        // Flush at cycle 20 of a CALC: nothing comes out.
        start(DIVU, 64'd1000, 64'd3, acc);
        while (cyc < acc + 20) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush calc out_valid", 64'(out_valid), 64'd0);
        check("flush calc in_ready", 64'(in_ready), 64'd1);
        repeat (80) @(negedge clk);
        check("flush calc quiet", 64'(out_valid), 64'd0);

        // in_valid together with flush in IDLE is not accepted.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = DIVU;
        dividend = 64'd5;
        divisor  = 64'd0;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush blocks accept", 64'(in_ready), 64'd1);
        repeat (5) @(negedge clk);
        check("flush accept quiet", 64'(out_valid), 64'd0);

        // Flush in DONE with out_ready high drops the result.
        out_ready = 1'b0;
        start(DIVU, 64'd9, 64'd0, acc);
        wait_valid("done flush wait");
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush done out_valid", 64'(out_valid), 64'd0);
        check("flush done in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset mid-CALC.
        start(DIV, 64'd123, 64'd4, acc);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid rst in_ready", 64'(in_ready), 64'd1);
        check("mid rst out_valid", 64'(out_valid), 64'd0);
        check("mid rst result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Unit still works after the reset.
        issue("post rst DIV 100/7", DIV, 64'd100, 64'd7, 64'd14, 67);
        drain();
        repeat (5) @(negedge clk);
        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
